// File: rtl/cursor_cmd_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cursor_cmd_ctrl                                                          |
// | Debounced button cursor with auto-repeat plus reveal/flag command issue. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cursor_cmd_ctrl #(
  parameter int GRID_W     = 8,
  parameter int GRID_H     = 8,
  parameter int DEB_CYCLES = 500000,
  parameter int RPT_DELAY  = 25000000,
  parameter int RPT_PERIOD = 7500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arriba,
  input  logic       abajo,
  input  logic       izquierda,
  input  logic       derecha,
  input  logic       mostrar,
  input  logic       mostrar_flag,
  input  logic       cmd_ready,
  output logic [3:0] x_select,
  output logic [3:0] y_select,
  output logic       cmd_valid,
  output logic       cmd_flag,
  output logic [3:0] cmd_x,
  output logic [3:0] cmd_y
);

  localparam int c_btn_n   = 6;
  localparam int c_dir_n   = 4;
  localparam int c_deb_w   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int c_rpt_max = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int c_rpt_w   = (c_rpt_max > 1) ? $clog2(c_rpt_max) : 1;

  localparam logic [c_deb_w-1:0] c_deb_last   = c_deb_w'(DEB_CYCLES - 1);
  localparam logic [c_rpt_w-1:0] c_delay_last = c_rpt_w'(RPT_DELAY - 1);
  localparam logic [c_rpt_w-1:0] c_per_last   = c_rpt_w'(RPT_PERIOD - 1);
  localparam logic [3:0]         c_x_max      = 4'(GRID_W - 1);
  localparam logic [3:0]         c_y_max      = 4'(GRID_H - 1);

  // Button index map: 0 up, 1 down, 2 left, 3 right, 4 reveal, 5 flag
  localparam int c_up   = 0;
  localparam int c_down = 1;
  localparam int c_left = 2;
  localparam int c_rght = 3;
  localparam int c_rev  = 4;
  localparam int c_flg  = 5;

  generate
    if (GRID_W < 1 || GRID_W > 16 || GRID_H < 1 || GRID_H > 16) begin : g_grid_check
      $error("cursor_cmd_ctrl: GRID_W and GRID_H must be within 1..16");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  logic [c_btn_n-1:0] w_raw;
  logic [c_btn_n-1:0] w_deb;
  logic [c_btn_n-1:0] w_press;
  logic [c_dir_n-1:0] w_rpt;
  logic [c_dir_n-1:0] w_step;

  state_t     r_state;
  logic [3:0] r_x;
  logic [3:0] r_y;
  logic       r_cmd_valid;
  logic       r_cmd_flag;
  logic [3:0] r_cmd_x;
  logic [3:0] r_cmd_y;

  assign w_raw = {mostrar_flag, mostrar, derecha, izquierda, abajo, arriba};

  // Synchroniser, debounce counter and one-cycle press pulse per button
  genvar gi;
  generate
    for (gi = 0; gi < c_btn_n; gi++) begin : g_btn
      logic               r_sync1;
      logic               r_sync2;
      logic               r_level;
      logic               r_pulse;
      logic [c_deb_w-1:0] r_cnt;

      always_ff @(posedge clk) begin
        if (!rst) begin
          r_sync1 <= 1'b0;
          r_sync2 <= 1'b0;
          r_level <= 1'b0;
          r_pulse <= 1'b0;
          r_cnt   <= '0;
        end else begin
          r_sync1 <= w_raw[gi];
          r_sync2 <= r_sync1;
          r_pulse <= 1'b0;
          if (r_sync2 != r_level) begin
            if (r_cnt == c_deb_last) begin
              r_level <= r_sync2;
              r_pulse <= r_sync2;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + c_deb_w'(1);
            end
          end else begin
            r_cnt <= '0;
          end
        end
      end

      assign w_deb[gi]   = r_level;
      assign w_press[gi] = r_pulse;
    end
  endgenerate

  // Auto-repeat counts from the cycle after the debounced level rises
  generate
    for (gi = 0; gi < c_dir_n; gi++) begin : g_rpt
      logic               r_started;
      logic               r_pulse;
      logic [c_rpt_w-1:0] r_cnt;

      always_ff @(posedge clk) begin
        if (!rst || !w_deb[gi]) begin
          r_started <= 1'b0;
          r_pulse   <= 1'b0;
          r_cnt     <= '0;
        end else begin
          r_pulse <= 1'b0;
          if (!r_started) begin
            if (r_cnt == c_delay_last) begin
              r_pulse   <= 1'b1;
              r_started <= 1'b1;
              r_cnt     <= '0;
            end else begin
              r_cnt <= r_cnt + c_rpt_w'(1);
            end
          end else if (r_cnt == c_per_last) begin
            r_pulse <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + c_rpt_w'(1);
          end
        end
      end

      assign w_rpt[gi] = r_pulse;
    end
  endgenerate

  assign w_step = w_press[c_dir_n-1:0] | w_rpt;

  // Opposite steps on one axis cancel; the cursor is frozen while a command waits
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_x <= 4'd0;
      r_y <= 4'd0;
    end else if (r_state != ST_ISSUE) begin
      if (w_step[c_rght] && !w_step[c_left] && r_x != c_x_max) begin
        r_x <= r_x + 4'd1;
      end else if (w_step[c_left] && !w_step[c_rght] && r_x != 4'd0) begin
        r_x <= r_x - 4'd1;
      end
      if (w_step[c_down] && !w_step[c_up] && r_y != c_y_max) begin
        r_y <= r_y + 4'd1;
      end else if (w_step[c_up] && !w_step[c_down] && r_y != 4'd0) begin
        r_y <= r_y - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_cmd_valid <= 1'b0;
      r_cmd_flag  <= 1'b0;
      r_cmd_x     <= 4'd0;
      r_cmd_y     <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_press[c_rev] || w_press[c_flg]) begin
            r_state     <= ST_ISSUE;
            r_cmd_valid <= 1'b1;
            r_cmd_flag  <= !w_press[c_rev];
            r_cmd_x     <= r_x;
            r_cmd_y     <= r_y;
          end
        end
        ST_ISSUE: begin
          if (r_cmd_valid && cmd_ready) begin
            r_state     <= ST_HOLD;
            r_cmd_valid <= 1'b0;
          end
        end
        ST_HOLD: begin
          // r_cmd_flag still names the button that launched the command
          if (!(r_cmd_flag ? w_deb[c_flg] : w_deb[c_rev])) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_cmd_valid <= 1'b0;
        end
      endcase
    end
  end

  assign x_select  = r_x;
  assign y_select  = r_y;
  assign cmd_valid = r_cmd_valid;
  assign cmd_flag  = r_cmd_flag;
  assign cmd_x     = r_cmd_x;
  assign cmd_y     = r_cmd_y;

endmodule
`default_nettype wire

// File: tb/tb_cursor_cmd_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cursor_cmd_ctrl                                                       |
// | Directed self-checking bench for cursor_cmd_ctrl.                        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_cursor_cmd_ctrl;

  logic       clk;
  logic       rst;
  logic [5:0] btn;
  logic       cmd_ready;
  logic [3:0] x_select;
  logic [3:0] y_select;
  logic       cmd_valid;
  logic       cmd_flag;
  logic [3:0] cmd_x;
  logic [3:0] cmd_y;

  int n_checks;
  int n_fail;

  cursor_cmd_ctrl #(
    .GRID_W    (8),
    .GRID_H    (8),
    .DEB_CYCLES(4),
    .RPT_DELAY (20),
    .RPT_PERIOD(8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .arriba      (btn[0]),
    .abajo       (btn[1]),
    .izquierda   (btn[2]),
    .derecha     (btn[3]),
    .mostrar     (btn[4]),
    .mostrar_flag(btn[5]),
    .cmd_ready   (cmd_ready),
    .x_select    (x_select),
    .y_select    (y_select),
    .cmd_valid   (cmd_valid),
    .cmd_flag    (cmd_flag),
    .cmd_x       (cmd_x),
    .cmd_y       (cmd_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tap(input int idx);
    btn[idx] = 1'b1;
    tick(10);
    btn[idx] = 1'b0;
    tick(10);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick(3);
    n_checks++;
    if ({x_select, y_select} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_cursor: got (%0d,%0d) expected (0,0)", x_select, y_select);
    end
    n_checks++;
    if ({cmd_valid, cmd_flag, cmd_x, cmd_y} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_cmd: got v=%0b f=%0b x=%0d y=%0d expected all 0", cmd_valid, cmd_flag, cmd_x, cmd_y);
    end
    rst = 1'b1;
    tick(1);
  endtask

  task automatic test_bounce;
    btn[3] = 1'b1;
    tick(3);
    btn[3] = 1'b0;
    tick(12);
    n_checks++;
    if (x_select !== 4'd0) begin
      n_fail++;
      $display("FAIL bounce_no_move: got x=%0d expected 0", x_select);
    end
    tap(3);
    n_checks++;
    if (x_select !== 4'd1) begin
      n_fail++;
      $display("FAIL single_step: got x=%0d expected 1", x_select);
    end
  endtask

  task automatic test_clamp;
    repeat (6) tap(3);
    repeat (3) tap(1);
    n_checks++;
    if ({x_select, y_select} !== {4'd7, 4'd3}) begin
      n_fail++;
      $display("FAIL reach_7_3: got (%0d,%0d) expected (7,3)", x_select, y_select);
    end
    tap(3);
    n_checks++;
    if ({x_select, y_select} !== {4'd7, 4'd3}) begin
      n_fail++;
      $display("FAIL clamp_right: got (%0d,%0d) expected (7,3)", x_select, y_select);
    end
  endtask

  task automatic test_repeat;
    logic [3:0] exp_x;
    btn[2] = 1'b1;
    for (int t = 1; t <= 60; t++) begin
      tick(1);
      if (t < 7)       exp_x = 4'd7;
      else if (t < 27) exp_x = 4'd6;
      else if (t < 35) exp_x = 4'd5;
      else if (t < 43) exp_x = 4'd4;
      else             exp_x = 4'd3;
      n_checks++;
      if (x_select !== exp_x) begin
        n_fail++;
        $display("FAIL repeat_t%0d: got x=%0d expected %0d", t, x_select, exp_x);
      end
      if (t == 40) btn[2] = 1'b0;
    end
    tick(10);
    tap(2);
    n_checks++;
    if (x_select !== 4'd2) begin
      n_fail++;
      $display("FAIL repeat_cleared: got x=%0d expected 2", x_select);
    end
    repeat (3) tap(2);
    n_checks++;
    if (x_select !== 4'd0) begin
      n_fail++;
      $display("FAIL clamp_left: got x=%0d expected 0", x_select);
    end
  endtask

  task automatic test_cancel;
    btn[0] = 1'b1;
    btn[1] = 1'b1;
    tick(10);
    btn[0] = 1'b0;
    btn[1] = 1'b0;
    tick(10);
    n_checks++;
    if ({x_select, y_select} !== {4'd0, 4'd3}) begin
      n_fail++;
      $display("FAIL up_down_cancel: got (%0d,%0d) expected (0,3)", x_select, y_select);
    end
    repeat (2) tap(3);
    repeat (2) tap(1);
    n_checks++;
    if ({x_select, y_select} !== {4'd2, 4'd5}) begin
      n_fail++;
      $display("FAIL reach_2_5: got (%0d,%0d) expected (2,5)", x_select, y_select);
    end
  endtask

  task automatic test_command;
    bit seen;
    cmd_ready = 1'b0;
    btn[4] = 1'b1;
    tick(6);
    n_checks++;
    if (cmd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL cmd_early: got valid=%0b expected 0", cmd_valid);
    end
    tick(1);
    n_checks++;
    if ({cmd_valid, cmd_flag, cmd_x, cmd_y} !== {1'b1, 1'b0, 4'd2, 4'd5}) begin
      n_fail++;
      $display("FAIL cmd_issue: got v=%0b f=%0b x=%0d y=%0d expected v=1 f=0 x=2 y=5", cmd_valid, cmd_flag, cmd_x, cmd_y);
    end
    btn[3] = 1'b1;
    for (int t = 0; t < 10; t++) begin
      tick(1);
      n_checks++;
      if ({cmd_valid, cmd_flag, cmd_x, cmd_y, x_select} !== {1'b1, 1'b0, 4'd2, 4'd5, 4'd2}) begin
        n_fail++;
        $display("FAIL cmd_stable_%0d: got v=%0b f=%0b x=%0d y=%0d cur_x=%0d expected v=1 f=0 x=2 y=5 cur_x=2", t, cmd_valid, cmd_flag, cmd_x, cmd_y, x_select);
      end
    end
    cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0;
    btn[3] = 1'b0;
    n_checks++;
    if (cmd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL cmd_accept: got valid=%0b expected 0", cmd_valid);
    end
    seen = 1'b0;
    for (int t = 0; t < 30; t++) begin
      tick(1);
      if (cmd_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0 || x_select !== 4'd2) begin
      n_fail++;
      $display("FAIL cmd_held_quiet: got second=%0b x=%0d expected second=0 x=2", seen, x_select);
    end
    btn[4] = 1'b0;
    tick(12);
    tap(3);
    n_checks++;
    if (x_select !== 4'd3) begin
      n_fail++;
      $display("FAIL move_after_cmd: got x=%0d expected 3", x_select);
    end
  endtask

  task automatic test_both;
    int         n_valid;
    logic       got_flag;
    logic [3:0] got_x;
    logic [3:0] got_y;
    cmd_ready = 1'b1;
    btn[4] = 1'b1;
    btn[5] = 1'b1;
    n_valid = 0;
    got_flag = 1'bx;
    got_x = 4'hx;
    got_y = 4'hx;
    for (int t = 0; t < 40; t++) begin
      tick(1);
      if (cmd_valid) begin
        n_valid++;
        got_flag = cmd_flag;
        got_x = cmd_x;
        got_y = cmd_y;
      end
    end
    btn[4] = 1'b0;
    btn[5] = 1'b0;
    tick(12);
    n_checks++;
    if (n_valid !== 1) begin
      n_fail++;
      $display("FAIL both_count: got %0d commands expected 1", n_valid);
    end
    n_checks++;
    if ({got_flag, got_x, got_y} !== {1'b0, 4'd3, 4'd5}) begin
      n_fail++;
      $display("FAIL both_reveal: got f=%0b x=%0d y=%0d expected f=0 x=3 y=5", got_flag, got_x, got_y);
    end
    btn[5] = 1'b1;
    n_valid = 0;
    for (int t = 0; t < 20; t++) begin
      tick(1);
      if (cmd_valid) begin
        n_valid++;
        got_flag = cmd_flag;
      end
    end
    btn[5] = 1'b0;
    tick(12);
    cmd_ready = 1'b0;
    n_checks++;
    if (n_valid !== 1 || got_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL flag_cmd: got count=%0d f=%0b expected count=1 f=1", n_valid, got_flag);
    end
  endtask

  task automatic test_reset_mid;
    bit seen;
    cmd_ready = 1'b0;
    btn[4] = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      tick(1);
      if (cmd_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_issue: got valid=0 within 20 cycles expected 1");
    end
    btn[4] = 1'b0;
    rst = 1'b0;
    tick(1);
    n_checks++;
    if ({cmd_valid, x_select, y_select} !== 9'd0) begin
      n_fail++;
      $display("FAIL mid_reset: got v=%0b (%0d,%0d) expected v=0 (0,0)", cmd_valid, x_select, y_select);
    end
    rst = 1'b1;
    tick(12);
    tap(4);
    n_checks++;
    if ({cmd_valid, cmd_flag, cmd_x, cmd_y} !== {1'b1, 1'b0, 4'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL post_reset_idle: got v=%0b f=%0b x=%0d y=%0d expected v=1 f=0 x=0 y=0", cmd_valid, cmd_flag, cmd_x, cmd_y);
    end
    cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0;
    n_checks++;
    if (cmd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_accept: got valid=%0b expected 0", cmd_valid);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    btn       = 6'd0;
    cmd_ready = 1'b0;
    rst       = 1'b0;
    test_reset;
    test_bounce;
    test_clamp;
    test_repeat;
    test_cancel;
    test_command;
    test_both;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
